// File: rtl/tx_packetizer_pkg.sv
// Shared constants, state encoding and checksum helpers for the host-bound packet framer.
package tx_packetizer_pkg;

    localparam logic [7:0] pkt_sync          = 8'hA5;
    localparam logic [7:0] pkt_type_mcp      = 8'h01;
    localparam logic [7:0] pkt_type_ccd_line = 8'h02;
    localparam logic [7:0] pkt_type_ad_conf  = 8'h03;

    // Gray-coded along the normal path: IDLE→SYNC→TYPE→LEN_LO→LEN_HI→WAIT_WORD→PAYLOAD→CSUM.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_SYNC      = 3'b001,
        ST_TYPE      = 3'b011,
        ST_LEN_LO    = 3'b010,
        ST_LEN_HI    = 3'b110,
        ST_WAIT_WORD = 3'b111,
        ST_PAYLOAD   = 3'b101,
        ST_CSUM      = 3'b100
    } tx_state_e;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    function automatic logic is_emit_state(input tx_state_e state);
        logic emit;
        case (state)
            ST_SYNC, ST_TYPE, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_CSUM: emit = 1'b1;
            default:                                                     emit = 1'b0;
        endcase
        return emit;
    endfunction

endpackage

// File: rtl/tx_packetizer.sv
// Frames producer words into SYNC/TYPE/LEN/payload/CSUM packets and writes them byte-wise into tx_fifo.
module tx_packetizer
    import tx_packetizer_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 2,
    parameter logic [7:0]  SYNC_BYTE  = pkt_sync
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pkt_start,
    input  logic [7:0]              pkt_type,
    input  logic [15:0]             pkt_len,
    output logic                    busy,
    input  logic [8*WORD_BYTES-1:0] word_data,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [7:0]              tx_fifo_wdata,
    output logic                    tx_fifo_winc,
    input  logic                    tx_fifo_wfull
);

    localparam int unsigned WORD_W    = 8 * WORD_BYTES;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

    tx_state_e         state_r;
    logic [7:0]        type_r;
    logic [7:0]        csum_r;
    logic [7:0]        wdata_r;
    logic [15:0]       word_cnt_r;
    logic [WORD_W-1:0] shreg_r;
    logic [1:0]        byte_cnt_r;
    logic              busy_r;
    logic              word_ready_r;

    logic              winc_s;
    logic [7:0]        csum_next_s;
    logic [WORD_W-1:0] shreg_next_s;
    logic [15:0]       word_cnt_dec_s;

    // Write strobe is gated by full in the same cycle so a byte is never pushed into a full fifo.
    always_comb begin
        winc_s = 1'b0;
        if (is_emit_state(state_r)) begin
            winc_s = ~tx_fifo_wfull;
        end else begin
            winc_s = 1'b0;
        end
    end

    // Next-value helpers shared by several state transitions.
    always_comb begin
        csum_next_s    = csum_add(csum_r, wdata_r);
        shreg_next_s   = shreg_r >> 8;
        word_cnt_dec_s = word_cnt_r - 16'd1;
    end

    // Packet sequencer: each emit state holds its byte in wdata_r until a cycle with winc_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            type_r       <= 8'h00;
            csum_r       <= 8'h00;
            wdata_r      <= 8'h00;
            word_cnt_r   <= 16'h0000;
            shreg_r      <= '0;
            byte_cnt_r   <= 2'd0;
            busy_r       <= 1'b0;
            word_ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pkt_start) begin
                        type_r     <= pkt_type;
                        word_cnt_r <= pkt_len;
                        csum_r     <= 8'h00;
                        wdata_r    <= SYNC_BYTE;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (winc_s) begin
                        wdata_r <= type_r;
                        state_r <= ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    if (winc_s) begin
                        csum_r  <= csum_next_s;
                        wdata_r <= word_cnt_r[7:0];
                        state_r <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (winc_s) begin
                        csum_r  <= csum_next_s;
                        wdata_r <= word_cnt_r[15:8];
                        state_r <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (winc_s) begin
                        csum_r <= csum_next_s;
                        if (word_cnt_r != 16'h0000) begin
                            word_ready_r <= 1'b1;
                            state_r      <= ST_WAIT_WORD;
                        end else begin
                            wdata_r <= csum_next_s;
                            state_r <= ST_CSUM;
                        end
                    end
                end
                ST_WAIT_WORD: begin
                    if (word_valid) begin
                        shreg_r      <= word_data;
                        wdata_r      <= word_data[7:0];
                        byte_cnt_r   <= 2'd0;
                        word_ready_r <= 1'b0;
                        state_r      <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (winc_s) begin
                        csum_r <= csum_next_s;
                        if (byte_cnt_r == LAST_BYTE) begin
                            word_cnt_r <= word_cnt_dec_s;
                            if (word_cnt_dec_s != 16'h0000) begin
                                word_ready_r <= 1'b1;
                                state_r      <= ST_WAIT_WORD;
                            end else begin
                                // Checksum must include the payload byte leaving this cycle.
                                wdata_r <= csum_next_s;
                                state_r <= ST_CSUM;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                            shreg_r    <= shreg_next_s;
                            wdata_r    <= shreg_next_s[7:0];
                        end
                    end
                end
                ST_CSUM: begin
                    if (winc_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r       <= 1'b0;
                    word_ready_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign word_ready    = word_ready_r;
    assign tx_fifo_wdata = wdata_r;
    assign tx_fifo_winc  = winc_s;

endmodule

// File: tb/tb_tx_packetizer.sv
// Scoreboard bench: two packetizers (2- and 4-byte words) share control inputs; a packet-level model predicts each byte stream.
module tb_tx_packetizer;
    import tx_packetizer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_start = 1'b0;
    logic [7:0]  pkt_type = 8'h00;
    logic [15:0] pkt_len = 16'h0000;
    logic        wfull = 1'b0;

    logic        busy2, busy4, word_ready2, word_ready4, winc2, winc4;
    logic [7:0]  wdata2, wdata4;
    logic        word_valid2 = 1'b0;
    logic        word_valid4 = 1'b0;
    logic [15:0] word_data2 = 16'h0000;
    logic [31:0] word_data4 = 32'h0;

    logic [7:0]  exp2_q[$];
    logic [7:0]  exp4_q[$];
    logic [15:0] word2_q[$];
    logic [31:0] word4_q[$];
    logic [15:0] dir2_q[$];
    logic [31:0] dir4_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int full_mode = 0;
    int word_stall = 0;
    int burst_left = 0;
    bit burst_done = 1'b0;
    int busy_tot2 = 0;
    int busy_tot4 = 0;
    bit took2, took4;

    always #10 clk = ~clk;

    tx_packetizer #(.WORD_BYTES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .pkt_type(pkt_type), .pkt_len(pkt_len),
        .busy(busy2), .word_data(word_data2), .word_valid(word_valid2), .word_ready(word_ready2),
        .tx_fifo_wdata(wdata2), .tx_fifo_winc(winc2), .tx_fifo_wfull(wfull)
    );

    tx_packetizer #(.WORD_BYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .pkt_type(pkt_type), .pkt_len(pkt_len),
        .busy(busy4), .word_data(word_data4), .word_valid(word_valid4), .word_ready(word_ready4),
        .tx_fifo_wdata(wdata4), .tx_fifo_winc(winc4), .tx_fifo_wfull(wfull)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Byte monitors: every written byte is popped from the expected stream.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy2) busy_tot2++;
            if (wfull) check("winc2_while_full", {31'd0, winc2}, 32'd0);
            if (winc2) begin
                if (exp2_q.size() == 0) check("byte2_unexpected", {24'd0, wdata2}, 32'hFFFF_FFFF);
                else check("byte2", {24'd0, wdata2}, {24'd0, exp2_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy4) busy_tot4++;
            if (wfull) check("winc4_while_full", {31'd0, winc4}, 32'd0);
            if (winc4) begin
                if (exp4_q.size() == 0) check("byte4_unexpected", {24'd0, wdata4}, 32'hFFFF_FFFF);
                else check("byte4", {24'd0, wdata4}, {24'd0, exp4_q.pop_front()});
            end
        end
    end

    // Word producers: offer the queue head and hold it until a handshake.
    always @(posedge clk) begin
        took2 = word_valid2 && word_ready2 && rst_n;
        #1;
        if (!rst_n) begin
            word_valid2 = 1'b0;
        end else begin
            if (took2) begin
                void'(word2_q.pop_front());
                word_valid2 = 1'b0;
            end
            if (!word_valid2 && word2_q.size() != 0 && (word_stall == 0 || $urandom_range(2, 0) == 0)) begin
                word_valid2 = 1'b1;
                word_data2  = word2_q[0];
            end
        end
    end

    always @(posedge clk) begin
        took4 = word_valid4 && word_ready4 && rst_n;
        #1;
        if (!rst_n) begin
            word_valid4 = 1'b0;
        end else begin
            if (took4) begin
                void'(word4_q.pop_front());
                word_valid4 = 1'b0;
            end
            if (!word_valid4 && word4_q.size() != 0 && (word_stall == 0 || $urandom_range(2, 0) == 0)) begin
                word_valid4 = 1'b1;
                word_data4  = word4_q[0];
            end
        end
    end

    // Backpressure: none, random, or a 3-cycle burst when byte 0x12 is about to be written.
    always @(posedge clk) begin
        #1;
        if (full_mode == 1) begin
            wfull = ($urandom_range(3, 0) == 0);
        end else if (full_mode == 2) begin
            if (burst_left > 0) begin
                wfull = 1'b1;
                burst_left--;
            end else if (!burst_done && busy2 && wdata2 == 8'h12) begin
                wfull      = 1'b1;
                burst_left = 2;
                burst_done = 1'b1;
            end else begin
                wfull = 1'b0;
            end
        end else begin
            wfull = 1'b0;
        end
    end

    // Model a whole packet for both word widths, queue words, then pulse pkt_start.
    task automatic send(input logic [7:0] t, input logic [15:0] n);
        logic [7:0]  s2, s4;
        logic [15:0] w2;
        logic [31:0] w4;
        s2 = 8'(t + n[7:0] + n[15:8]);
        s4 = s2;
        exp2_q.push_back(pkt_sync); exp2_q.push_back(t); exp2_q.push_back(n[7:0]); exp2_q.push_back(n[15:8]);
        exp4_q.push_back(pkt_sync); exp4_q.push_back(t); exp4_q.push_back(n[7:0]); exp4_q.push_back(n[15:8]);
        for (int i = 0; i < int'(n); i++) begin
            w2 = (dir2_q.size() != 0) ? dir2_q.pop_front() : 16'($urandom);
            w4 = (dir4_q.size() != 0) ? dir4_q.pop_front() : $urandom;
            word2_q.push_back(w2);
            word4_q.push_back(w4);
            for (int b = 0; b < 2; b++) begin
                exp2_q.push_back(w2[8*b +: 8]);
                s2 = 8'(s2 + w2[8*b +: 8]);
            end
            for (int b = 0; b < 4; b++) begin
                exp4_q.push_back(w4[8*b +: 8]);
                s4 = 8'(s4 + w4[8*b +: 8]);
            end
        end
        exp2_q.push_back(s2);
        exp4_q.push_back(s4);
        pkt_type  = t;
        pkt_len   = n;
        pkt_start = 1'b1;
        @(negedge clk);
        check("busy_before_accept", {30'd0, busy2, busy4}, 32'd0);
        @(posedge clk); #1;
        pkt_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int cycles = 0;
        while ((busy2 || busy4 || exp2_q.size() != 0 || exp4_q.size() != 0) && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_timeout"}, {31'd0, cycles >= limit}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int b2, b4;
        logic [7:0]  rt;
        logic [15:0] rl;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",       {30'd0, busy2, busy4}, 32'd0);
        check("rst_word_ready", {30'd0, word_ready2, word_ready4}, 32'd0);
        check("rst_winc",       {30'd0, winc2, winc4}, 32'd0);
        check("rst_wdata",      {16'd0, wdata2, wdata4}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty packet: first byte the cycle after start, busy for five cycles.
        b2 = busy_tot2; b4 = busy_tot4;
        send(pkt_type_mcp, 16'd0);
        @(negedge clk);
        check("first_byte_winc", {31'd0, winc2}, 32'd1);
        check("first_byte_sync", {24'd0, wdata2}, {24'd0, pkt_sync});
        wait_done("len0", 100);
        check("len0_busy2", busy_tot2 - b2, 32'd5);
        check("len0_busy4", busy_tot4 - b4, 32'd5);

        // Two words, no backpressure: header 4 + words*(1+WORD_BYTES) + 1 cycles.
        b2 = busy_tot2; b4 = busy_tot4;
        dir2_q = '{16'h1234, 16'hABCD};
        send(pkt_type_ccd_line, 16'd2);
        wait_done("len2", 200);
        check("len2_busy2", busy_tot2 - b2, 32'd11);
        check("len2_busy4", busy_tot4 - b4, 32'd15);

        // Same packet with fifo full for three cycles on the 0x12 byte.
        dir2_q = '{16'h1234, 16'hABCD};
        full_mode = 2; burst_done = 1'b0;
        send(pkt_type_ccd_line, 16'd2);
        wait_done("burst", 200);
        full_mode = 0;

        // Start pulse while busy must be ignored.
        dir2_q = '{16'h1234, 16'hABCD};
        send(pkt_type_ccd_line, 16'd2);
        repeat (5) @(posedge clk);
        #1;
        if (busy2 && busy4) begin
            pkt_type = pkt_type_ad_conf; pkt_len = 16'd5; pkt_start = 1'b1;
            @(posedge clk); #1;
            pkt_start = 1'b0;
        end
        wait_done("ignored_start", 200);
        repeat (3) begin
            @(negedge clk);
            check("no_second_pkt", {30'd0, winc2, busy2}, 32'd0);
        end
        @(posedge clk); #1;

        // Reset in the middle of a payload.
        send(pkt_type_ccd_line, 16'd3);
        for (int i = 0; i < 50 && !word_ready2; i++) @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrst_winc",       {30'd0, winc2, winc4}, 32'd0);
        check("midrst_busy",       {30'd0, busy2, busy4}, 32'd0);
        check("midrst_word_ready", {30'd0, word_ready2, word_ready4}, 32'd0);
        exp2_q.delete(); exp4_q.delete(); word2_q.delete(); word4_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(pkt_type_mcp, 16'd0);
        wait_done("after_rst", 100);

        // Single 4-byte word 0x00000155.
        dir4_q = '{32'h0000_0155};
        send(pkt_type_mcp, 16'd1);
        wait_done("wb4", 100);

        // Random packets under random backpressure and producer stalls.
        full_mode = 1; word_stall = 1;
        repeat (20) begin
            rt = 8'($urandom);
            rl = 16'($urandom_range(6, 0));
            send(rt, rl);
            wait_done("rand", 400);
        end
        full_mode = 0; word_stall = 0;

        send(pkt_type_ccd_line, 16'd300);
        wait_done("long", 4000);

        check("exp2_drained", exp2_q.size(), 32'd0);
        check("exp4_drained", exp4_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
